// File: rtl/pcie_k7_pipe_rate_ctrl_if.sv
// pcie_k7_pipe_rate_ctrl_if: per-lane PIPE rate request, GT rate-done handshake and PCLK select bundle
// master: core/GT/clock side (drives rate request, lock, rate-done pulses)
// slave:  rate sequencer (drives GT rate, PCLK select, Gen3, PHYSTATUS and status)
interface pcie_k7_pipe_rate_ctrl_if;
  logic [1:0] RATE_RATE_IN;
  logic       RATE_MMCM_LOCK;
  logic       RATE_TXRATEDONE;
  logic       RATE_RXRATEDONE;
  logic [2:0] RATE_TXRATE;
  logic [2:0] RATE_RXRATE;
  logic       RATE_PCLK_SEL;
  logic       RATE_GEN3;
  logic       RATE_PHYSTATUS;
  logic       RATE_IDLE;
  logic       RATE_TIMEOUT;
  logic [2:0] RATE_FSM;
  modport master (
    output RATE_RATE_IN, RATE_MMCM_LOCK, RATE_TXRATEDONE, RATE_RXRATEDONE,
    input  RATE_TXRATE, RATE_RXRATE, RATE_PCLK_SEL, RATE_GEN3, RATE_PHYSTATUS,
           RATE_IDLE, RATE_TIMEOUT, RATE_FSM
  );
  modport slave (
    input  RATE_RATE_IN, RATE_MMCM_LOCK, RATE_TXRATEDONE, RATE_RXRATEDONE,
    output RATE_TXRATE, RATE_RXRATE, RATE_PCLK_SEL, RATE_GEN3, RATE_PHYSTATUS,
           RATE_IDLE, RATE_TIMEOUT, RATE_FSM
  );
endinterface

// File: rtl/pcie_k7_pipe_rate_ctrl.sv
// pcie_k7_pipe_rate_ctrl: per-lane PIPE rate-change sequencer (GT rate, rate-done wait, PCLK switch, settle, PHYSTATUS)
// RATE_CLK/RATE_RST_N: block clock and async active-low reset
// bus (slave): rate request, MMCM lock, TX/RX rate-done in; TX/RX rate, PCLK select, Gen3,
//              PHYSTATUS pulse, idle, sticky timeout and debug state out
module pcie_k7_pipe_rate_ctrl #(
  parameter int PCIE_LINK_SPEED   = 3,
  parameter int PCIE_RATE_TIMEOUT = 1024,
  parameter int PCIE_PCLK_SETTLE  = 16
) (
  input logic                     RATE_CLK,
  input logic                     RATE_RST_N,
  pcie_k7_pipe_rate_ctrl_if.slave bus
);
  localparam int TW = PCIE_RATE_TIMEOUT > 1 ? $clog2(PCIE_RATE_TIMEOUT) : 1;
  localparam int SW = PCIE_PCLK_SETTLE > 1 ? $clog2(PCIE_PCLK_SETTLE) : 1;
  localparam logic [1:0] MAX = 2'(PCIE_LINK_SPEED - 1);
  typedef enum logic [2:0] {
    IDLE = 3'd0, CHANGE = 3'd1, WAIT_DONE = 3'd2, PCLK = 3'd3, SETTLE = 3'd4, STATUS = 3'd5
  } state_t;
  state_t state, next;
  logic [1:0] cur, target, req;
  logic tx_st, rx_st, done, tout, settled;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [2:0] rate;
  logic pclk_sel, gen3, phystatus, idle, timeout;
  // reserved request 3 reads as "stay put"; anything above the link speed clamps
  assign req = bus.RATE_RATE_IN == 2'd3 ? cur : bus.RATE_RATE_IN > MAX ? MAX : bus.RATE_RATE_IN;
  assign done = (tx_st | bus.RATE_TXRATEDONE) & (rx_st | bus.RATE_RXRATEDONE);
  assign tout = tcnt == TW'(PCIE_RATE_TIMEOUT - 1);
  assign settled = bus.RATE_MMCM_LOCK && scnt == SW'(PCIE_PCLK_SETTLE - 1);
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = (req != cur && bus.RATE_MMCM_LOCK) ? CHANGE : IDLE;
      CHANGE:    next = WAIT_DONE;
      WAIT_DONE: next = (done || tout) ? PCLK : WAIT_DONE;
      PCLK:      next = SETTLE;
      SETTLE:    next = settled ? STATUS : SETTLE;
      default:   next = IDLE;
    endcase
  end
  // idle/phystatus are registered from next state so they line up with the state they describe
  always_ff @(posedge RATE_CLK or negedge RATE_RST_N) begin
    if (!RATE_RST_N) begin
      state     <= IDLE;
      cur       <= 2'd0;
      target    <= 2'd0;
      tx_st     <= 1'b0;
      rx_st     <= 1'b0;
      tcnt      <= '0;
      scnt      <= '0;
      rate      <= 3'd0;
      pclk_sel  <= 1'b0;
      gen3      <= 1'b0;
      phystatus <= 1'b0;
      idle      <= 1'b1;
      timeout   <= 1'b0;
    end else begin
      state     <= next;
      idle      <= next == IDLE;
      phystatus <= next == STATUS;
      if (state == IDLE) target <= req;
      if (state == CHANGE) begin
        rate    <= {2'b00, target != 2'd0};
        tx_st   <= 1'b0;
        rx_st   <= 1'b0;
        timeout <= 1'b0;
        tcnt    <= '0;
      end
      if (state == WAIT_DONE) begin
        tx_st   <= tx_st | bus.RATE_TXRATEDONE;
        rx_st   <= rx_st | bus.RATE_RXRATEDONE;
        tcnt    <= tout ? tcnt : tcnt + 1'b1;
        timeout <= timeout | (tout & ~done);
      end
      if (state == PCLK) begin
        pclk_sel <= target != 2'd0;
        gen3     <= target == 2'd2;
        scnt     <= '0;
      end
      if (state == SETTLE) scnt <= !bus.RATE_MMCM_LOCK ? '0 : settled ? scnt : scnt + 1'b1;
      if (state == STATUS) cur <= target;
    end
  end
  assign bus.RATE_TXRATE    = rate;
  assign bus.RATE_RXRATE    = rate;
  assign bus.RATE_PCLK_SEL  = pclk_sel;
  assign bus.RATE_GEN3      = gen3;
  assign bus.RATE_PHYSTATUS = phystatus;
  assign bus.RATE_IDLE      = idle;
  assign bus.RATE_TIMEOUT   = timeout;
  assign bus.RATE_FSM       = state;
endmodule

// File: tb/tb_pcie_k7_pipe_rate_ctrl.sv
// tb_pcie_k7_pipe_rate_ctrl: scoreboard bench for the PIPE rate-change sequencer
module tb_pcie_k7_pipe_rate_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pcie_k7_pipe_rate_ctrl_if bus ();
  pcie_k7_pipe_rate_ctrl_if bus2 ();
  pcie_k7_pipe_rate_ctrl u_dut (.RATE_CLK(clk), .RATE_RST_N(rst_n), .bus(bus.slave));
  pcie_k7_pipe_rate_ctrl #(.PCIE_LINK_SPEED(2), .PCIE_RATE_TIMEOUT(8), .PCIE_PCLK_SETTLE(4))
    u_dut2 (.RATE_CLK(clk), .RATE_RST_N(rst_n), .bus(bus2.slave));
  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  tx;
    logic [2:0]  rx;
    logic        sel;
    logic        g3;
    logic        to;
  } ev_t;
  localparam logic [13:0] RST_SNAP = {3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
  ev_t obs[$], obs2[$], exp_q[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.RATE_PHYSTATUS)
      obs.push_back(ev_t'{32'(cyc), bus.RATE_TXRATE, bus.RATE_RXRATE, bus.RATE_PCLK_SEL, bus.RATE_GEN3, bus.RATE_TIMEOUT});
    if (bus2.RATE_PHYSTATUS)
      obs2.push_back(ev_t'{32'(cyc), bus2.RATE_TXRATE, bus2.RATE_RXRATE, bus2.RATE_PCLK_SEL, bus2.RATE_GEN3, bus2.RATE_TIMEOUT});
  end
  function automatic logic [13:0] snap(input bit which);
    return which ? {bus2.RATE_TXRATE, bus2.RATE_RXRATE, bus2.RATE_PCLK_SEL, bus2.RATE_GEN3, bus2.RATE_PHYSTATUS,
                    bus2.RATE_IDLE, bus2.RATE_TIMEOUT, bus2.RATE_FSM}
                 : {bus.RATE_TXRATE, bus.RATE_RXRATE, bus.RATE_PCLK_SEL, bus.RATE_GEN3, bus.RATE_PHYSTATUS,
                    bus.RATE_IDLE, bus.RATE_TIMEOUT, bus.RATE_FSM};
  endfunction
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic pulse_done(input bit which, input bit tx, input bit rx);
    if (which) begin
      bus2.RATE_TXRATEDONE = tx;
      bus2.RATE_RXRATEDONE = rx;
    end else begin
      bus.RATE_TXRATEDONE = tx;
      bus.RATE_RXRATEDONE = rx;
    end
    @(negedge clk);
    bus.RATE_TXRATEDONE = 1'b0;
    bus.RATE_RXRATEDONE = 1'b0;
    bus2.RATE_TXRATEDONE = 1'b0;
    bus2.RATE_RXRATEDONE = 1'b0;
  endtask
  task automatic start_req(input bit which, input logic [1:0] r, output int s);
    @(negedge clk);
    s = cyc;
    if (which) bus2.RATE_RATE_IN = r;
    else bus.RATE_RATE_IN = r;
  endtask
  task automatic get_obs(input bit which, input int budget, output bit got, output ev_t o);
    got = 1'b0;
    o = '0;
    for (int i = 0; i < budget && !got; i++) begin
      if (which && obs2.size() > 0) begin
        o = obs2.pop_front();
        got = 1'b1;
      end else if (!which && obs.size() > 0) begin
        o = obs.pop_front();
        got = 1'b1;
      end else @(negedge clk);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (snap(0) !== RST_SNAP) begin errors++; $display("FAIL reset: got %b want %b", snap(0), RST_SNAP); end
    checks++;
    if (snap(1) !== RST_SNAP) begin errors++; $display("FAIL reset2: got %b want %b", snap(1), RST_SNAP); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (snap(0) !== RST_SNAP) begin errors++; $display("FAIL post_reset: got %b want %b", snap(0), RST_SNAP); end
  endtask
  task automatic test_gen1_gen2();
    int s;
    bit got;
    ev_t o, e;
    start_req(0, 2'd1, s);
    exp_q.push_back(ev_t'{32'(s + 23), 3'd1, 3'd1, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    checks++;
    if ({bus.RATE_IDLE, bus.RATE_TXRATE, bus.RATE_FSM} !== {1'b0, 3'd0, 3'd1}) begin
      errors++; $display("FAIL g2 change: got idle/tx/fsm %b want %b", {bus.RATE_IDLE, bus.RATE_TXRATE, bus.RATE_FSM}, {1'b0, 3'd0, 3'd1});
    end
    @(negedge clk);
    checks++;
    if ({bus.RATE_TXRATE, bus.RATE_RXRATE, bus.RATE_FSM} !== {3'd1, 3'd1, 3'd2}) begin
      errors++; $display("FAIL g2 rate: got tx/rx/fsm %b want %b", {bus.RATE_TXRATE, bus.RATE_RXRATE, bus.RATE_FSM}, {3'd1, 3'd1, 3'd2});
    end
    wait_cyc(s + 5);
    pulse_done(0, 1'b1, 1'b1);
    checks++;
    if ({bus.RATE_PCLK_SEL, bus.RATE_FSM} !== {1'b0, 3'd3}) begin
      errors++; $display("FAIL g2 pclk: got sel/fsm %b want %b", {bus.RATE_PCLK_SEL, bus.RATE_FSM}, {1'b0, 3'd3});
    end
    @(negedge clk);
    checks++;
    if ({bus.RATE_PCLK_SEL, bus.RATE_FSM} !== {1'b1, 3'd4}) begin
      errors++; $display("FAIL g2 sel: got sel/fsm %b want %b", {bus.RATE_PCLK_SEL, bus.RATE_FSM}, {1'b1, 3'd4});
    end
    get_obs(0, 100, got, o);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL g2 phystatus: got %h seen=%0d want %h", o, got, e); end
    wait_cyc(s + 24);
    checks++;
    if ({bus.RATE_IDLE, bus.RATE_PHYSTATUS, bus.RATE_FSM} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL g2 idle: got idle/phy/fsm %b want %b", {bus.RATE_IDLE, bus.RATE_PHYSTATUS, bus.RATE_FSM}, {1'b1, 1'b0, 3'd0});
    end
  endtask
  task automatic test_gen2_gen3_gen1();
    int s;
    bit got;
    ev_t o, e;
    start_req(0, 2'd2, s);
    exp_q.push_back(ev_t'{32'(s + 24), 3'd1, 3'd1, 1'b1, 1'b1, 1'b0});
    wait_cyc(s + 3);
    pulse_done(0, 1'b1, 1'b0);
    wait_cyc(s + 5);
    checks++;
    if (bus.RATE_FSM !== 3'd2) begin errors++; $display("FAIL g3 half_done: got fsm %0d want 2", bus.RATE_FSM); end
    wait_cyc(s + 6);
    pulse_done(0, 1'b0, 1'b1);
    checks++;
    if ({bus.RATE_PCLK_SEL, bus.RATE_GEN3, bus.RATE_FSM} !== {1'b1, 1'b0, 3'd3}) begin
      errors++; $display("FAIL g3 pclk: got sel/g3/fsm %b want %b", {bus.RATE_PCLK_SEL, bus.RATE_GEN3, bus.RATE_FSM}, {1'b1, 1'b0, 3'd3});
    end
    get_obs(0, 100, got, o);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL g3 phystatus: got %h seen=%0d want %h", o, got, e); end
    start_req(0, 2'd0, s);
    exp_q.push_back(ev_t'{32'(s + 24), 3'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    wait_cyc(s + 1);
    pulse_done(0, 1'b1, 1'b1);
    wait_cyc(s + 4);
    pulse_done(0, 1'b0, 1'b1);
    checks++;
    if (bus.RATE_FSM !== 3'd2) begin errors++; $display("FAIL g1 change_drop: got fsm %0d want 2", bus.RATE_FSM); end
    wait_cyc(s + 6);
    pulse_done(0, 1'b1, 1'b0);
    checks++;
    if ({bus.RATE_PCLK_SEL, bus.RATE_GEN3, bus.RATE_FSM} !== {1'b1, 1'b1, 3'd3}) begin
      errors++; $display("FAIL g1 pclk: got sel/g3/fsm %b want %b", {bus.RATE_PCLK_SEL, bus.RATE_GEN3, bus.RATE_FSM}, {1'b1, 1'b1, 3'd3});
    end
    get_obs(0, 100, got, o);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL g1 phystatus: got %h seen=%0d want %h", o, got, e); end
    repeat (5) @(negedge clk);
    checks++;
    if (obs.size() != 0) begin errors++; $display("FAIL g1 single_pulse: got %0d extra want 0", obs.size()); end
  endtask
  task automatic test_timeout();
    int s;
    bit got;
    ev_t o, e;
    start_req(0, 2'd1, s);
    exp_q.push_back(ev_t'{32'(s + 1043), 3'd1, 3'd1, 1'b1, 1'b0, 1'b1});
    wait_cyc(s + 1025);
    checks++;
    if ({bus.RATE_FSM, bus.RATE_TIMEOUT} !== {3'd2, 1'b0}) begin
      errors++; $display("FAIL to wait: got fsm/to %b want %b", {bus.RATE_FSM, bus.RATE_TIMEOUT}, {3'd2, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({bus.RATE_FSM, bus.RATE_TIMEOUT} !== {3'd3, 1'b1}) begin
      errors++; $display("FAIL to pclk: got fsm/to %b want %b", {bus.RATE_FSM, bus.RATE_TIMEOUT}, {3'd3, 1'b1});
    end
    get_obs(0, 100, got, o);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL to phystatus: got %h seen=%0d want %h", o, got, e); end
    start_req(0, 2'd0, s);
    exp_q.push_back(ev_t'{32'(s + 20), 3'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    wait_cyc(s + 2);
    checks++;
    if (bus.RATE_TIMEOUT !== 1'b0) begin errors++; $display("FAIL to clear: got %b want 0", bus.RATE_TIMEOUT); end
    pulse_done(0, 1'b1, 1'b1);
    get_obs(0, 100, got, o);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL to next_phystatus: got %h seen=%0d want %h", o, got, e); end
  endtask
  task automatic test_lock_drop();
    int s, l;
    bit got;
    ev_t o, e;
    start_req(0, 2'd1, s);
    exp_q.push_back(ev_t'{32'(s + 28), 3'd1, 3'd1, 1'b1, 1'b0, 1'b0});
    wait_cyc(s + 2);
    pulse_done(0, 1'b1, 1'b1);
    wait_cyc(s + 9);
    bus.RATE_MMCM_LOCK = 1'b0;
    wait_cyc(s + 12);
    bus.RATE_MMCM_LOCK = 1'b1;
    get_obs(0, 100, got, o);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL lock settle_phystatus: got %h seen=%0d want %h", o, got, e); end
    bus.RATE_MMCM_LOCK = 1'b0;
    start_req(0, 2'd0, s);
    wait_cyc(s + 10);
    checks++;
    if ({bus.RATE_FSM, bus.RATE_IDLE} !== {3'd0, 1'b1}) begin
      errors++; $display("FAIL lock idle_hold: got fsm/idle %b want %b", {bus.RATE_FSM, bus.RATE_IDLE}, {3'd0, 1'b1});
    end
    bus.RATE_MMCM_LOCK = 1'b1;
    l = cyc;
    exp_q.push_back(ev_t'{32'(l + 20), 3'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    checks++;
    if (bus.RATE_FSM !== 3'd1) begin errors++; $display("FAIL lock rise_change: got fsm %0d want 1", bus.RATE_FSM); end
    wait_cyc(l + 2);
    pulse_done(0, 1'b1, 1'b1);
    get_obs(0, 100, got, o);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL lock rise_phystatus: got %h seen=%0d want %h", o, got, e); end
  endtask
  task automatic test_reserved();
    int s;
    start_req(0, 2'd3, s);
    wait_cyc(s + 20);
    checks++;
    if ({obs.size() == 0, bus.RATE_FSM, bus.RATE_IDLE} !== {1'b1, 3'd0, 1'b1}) begin
      errors++; $display("FAIL reserved: got pulses=%0d fsm=%0d idle=%b want 0/0/1", obs.size(), bus.RATE_FSM, bus.RATE_IDLE);
    end
    start_req(0, 2'd0, s);
    wait_cyc(s + 20);
    checks++;
    if ({obs.size() == 0, bus.RATE_FSM, bus.RATE_IDLE} !== {1'b1, 3'd0, 1'b1}) begin
      errors++; $display("FAIL same_rate: got pulses=%0d fsm=%0d idle=%b want 0/0/1", obs.size(), bus.RATE_FSM, bus.RATE_IDLE);
    end
  endtask
  task automatic test_clamp();
    int s;
    bit got;
    ev_t o, e;
    start_req(1, 2'd2, s);
    e = ev_t'{32'(s + 8), 3'd1, 3'd1, 1'b1, 1'b0, 1'b0};
    wait_cyc(s + 2);
    pulse_done(1, 1'b1, 1'b1);
    get_obs(1, 50, got, o);
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL clamp phystatus: got %h seen=%0d want %h", o, got, e); end
    start_req(1, 2'd3, s);
    wait_cyc(s + 20);
    checks++;
    if ({obs2.size() == 0, bus2.RATE_FSM} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL clamp reserved: got pulses=%0d fsm=%0d want 0/0", obs2.size(), bus2.RATE_FSM);
    end
    start_req(1, 2'd1, s);
    wait_cyc(s + 20);
    checks++;
    if ({obs2.size() == 0, bus2.RATE_FSM} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL clamp same_rate: got pulses=%0d fsm=%0d want 0/0", obs2.size(), bus2.RATE_FSM);
    end
    start_req(1, 2'd0, s);
    e = ev_t'{32'(s + 15), 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    get_obs(1, 50, got, o);
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL clamp timeout_phystatus: got %h seen=%0d want %h", o, got, e); end
  endtask
  task automatic test_reset_mid();
    int s;
    bit got;
    ev_t o, e;
    start_req(0, 2'd1, s);
    wait_cyc(s + 4);
    checks++;
    if (bus.RATE_FSM !== 3'd2) begin errors++; $display("FAIL rmid wait: got fsm %0d want 2", bus.RATE_FSM); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (snap(0) !== RST_SNAP) begin errors++; $display("FAIL rmid async: got %b want %b", snap(0), RST_SNAP); end
    repeat (4) @(negedge clk);
    checks++;
    if (obs.size() != 0) begin errors++; $display("FAIL rmid no_phystatus: got %0d pulses want 0", obs.size()); end
    rst_n = 1'b1;
    s = cyc;
    exp_q.push_back(ev_t'{32'(s + 20), 3'd1, 3'd1, 1'b1, 1'b0, 1'b0});
    wait_cyc(s + 2);
    pulse_done(0, 1'b1, 1'b1);
    get_obs(0, 100, got, o);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL rmid fresh_phystatus: got %h seen=%0d want %h", o, got, e); end
    repeat (5) @(negedge clk);
    checks++;
    if (obs.size() + obs2.size() + exp_q.size() != 0) begin
      errors++; $display("FAIL drain: got %0d leftover events want 0", obs.size() + obs2.size() + exp_q.size());
    end
  endtask
  initial begin
    bus.RATE_RATE_IN = 2'd0;
    bus.RATE_MMCM_LOCK = 1'b1;
    bus.RATE_TXRATEDONE = 1'b0;
    bus.RATE_RXRATEDONE = 1'b0;
    bus2.RATE_RATE_IN = 2'd0;
    bus2.RATE_MMCM_LOCK = 1'b1;
    bus2.RATE_TXRATEDONE = 1'b0;
    bus2.RATE_RXRATEDONE = 1'b0;
    test_reset();
    test_gen1_gen2();
    test_gen2_gen3_gen1();
    test_timeout();
    test_lock_drop();
    test_reserved();
    test_clamp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within bound");
    $fatal(1);
  end
endmodule
